// File: rtl/logic_bist_ctrl.sv
// Exhaustive-pattern BIST harness: drives every IN_W-bit pattern onto a small combinational
// circuit, compacts its responses in a Galois MISR and compares the signature with a golden value.
module logic_bist_ctrl #(
    parameter int unsigned             IN_W      = 3,
    parameter int unsigned             OUT_W     = 3,
    parameter int unsigned             SIG_W     = 16,
    parameter logic [SIG_W-1:0]        MISR_POLY = 16'h1021,
    parameter logic [SIG_W-1:0]        MISR_SEED = 16'h0000,
    parameter int unsigned             RESP_LAT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  stim,
    output logic             stim_valid,
    input  logic [OUT_W-1:0] resp,
    input  logic [SIG_W-1:0] golden,
    output logic [SIG_W-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam int unsigned CNT_W    = IN_W + 1;
    localparam int unsigned PATTERNS = 2 ** IN_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERNS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IN_W-1:0]   stim_q, stim_d;
    logic              stim_valid_q, stim_valid_d;
    logic              rv_q, rv_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic              pass_q, pass_d;
    logic              rv;
    logic [SIG_W-1:0]  misr_next;

    // Response qualifier follows the stimulus through the DUT's own latency.
    assign rv = (RESP_LAT == 0) ? stim_valid_q : rv_q;

    assign misr_next = (sig_q << 1)
                     ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
                     ^ SIG_W'(resp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            stim_q       <= '0;
            stim_valid_q <= 1'b0;
            rv_q         <= 1'b0;
            sig_q        <= MISR_SEED;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stim_q       <= stim_d;
            stim_valid_q <= stim_valid_d;
            rv_q         <= rv_d;
            sig_q        <= sig_d;
            pass_q       <= pass_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stim_d       = stim_q;
        stim_valid_d = stim_valid_q;
        rv_d         = stim_valid_q;
        pass_d       = pass_q;
        sig_d        = sig_q;

        // Compaction is independent of abort so an aborted run keeps its last partial signature.
        if (rv) begin
            sig_d = misr_next;
        end

        if (abort) begin
            state_d      = ST_IDLE;
            stim_valid_d = 1'b0;
            rv_d         = 1'b0;
            pass_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d      = ST_RUN;
                        cnt_d        = '0;
                        stim_d       = '0;
                        stim_valid_d = 1'b1;
                        sig_d        = MISR_SEED;
                        pass_d       = 1'b0;
                    end
                end
                ST_RUN: begin
                    cnt_d  = cnt_q + 1'b1;
                    stim_d = cnt_q[IN_W-1:0] + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        stim_valid_d = 1'b0;
                        if (RESP_LAT == 0) begin
                            state_d = ST_DONE;
                            pass_d  = (sig_d == golden);
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_d = ST_DONE;
                    pass_d  = (sig_d == golden);
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign stim       = stim_q;
    assign stim_valid = stim_valid_q;
    assign sig        = sig_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;

endmodule

// File: tb/tb_logic_bist_ctrl.sv
// Self-checking bench for logic_bist_ctrl: combinational, registered and seeded instances
// against the 3-in/3-out redundant-logic example circuit.
module tb_logic_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] golden;
    logic        zero_resp;

    logic [2:0]  stim, resp;
    logic        stim_valid, busy, done, pass;
    logic [15:0] sig;

    logic [2:0]  stim_l1, resp_l1;
    logic        stim_valid_l1, busy_l1, done_l1, pass_l1;
    logic [15:0] sig_l1;

    logic [2:0]  stim_sd;
    logic        stim_valid_sd, busy_sd, done_sd, pass_sd;
    logic [15:0] sig_sd;

    int checks   = 0;
    int failures = 0;
    logic [15:0] sb[$];

    typedef struct {
        logic [15:0] gold;
        bit          zero;
        int          mid_start;
        logic [15:0] exp_sig;
        bit          exp_pass;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    function automatic logic [2:0] dut_fn(input logic [2:0] s);
        logic a, b, c;
        a = s[2];
        b = s[1];
        c = s[0];
        return {a & b, (a & b) ^ (a ^ b), a & b & c};
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [2:0] r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, r};
    endfunction

    assign resp = zero_resp ? 3'b000 : dut_fn(stim);

    always_ff @(posedge clk) begin
        resp_l1 <= zero_resp ? 3'b000 : dut_fn(stim_l1);
    end

    logic_bist_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .stim(stim), .stim_valid(stim_valid), .resp(resp), .golden(golden),
        .sig(sig), .busy(busy), .done(done), .pass(pass)
    );

    logic_bist_ctrl #(.RESP_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .stim(stim_l1), .stim_valid(stim_valid_l1), .resp(resp_l1), .golden(golden),
        .sig(sig_l1), .busy(busy_l1), .done(done_l1), .pass(pass_l1)
    );

    logic_bist_ctrl #(.MISR_SEED(16'h8000)) u_dut_sd (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .stim(stim_sd), .stim_valid(stim_valid_sd), .resp(3'b000), .golden(golden),
        .sig(sig_sd), .busy(busy_sd), .done(done_sd), .pass(pass_sd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entered and left at a negedge; start is taken on the following rising edge.
    task automatic run_main(input vec_t v);
        logic [15:0] m;
        logic [2:0]  r;
        golden    = v.gold;
        zero_resp = v.zero;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run_done_low", {31'b0, done}, 32'd0);
        chk("run_seed", {16'b0, sig}, 32'h0000);
        m = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            chk("run_stim", {29'b0, stim}, k);
            chk("run_stim_valid", {31'b0, stim_valid}, 32'd1);
            chk("run_busy", {31'b0, busy}, 32'd1);
            if (k == v.mid_start) start = 1'b1;
            r = v.zero ? 3'b000 : dut_fn(3'(k));
            m = misr(m, r);
            sb.push_back(m);
            @(negedge clk);
            start = 1'b0;
            if (sb.size() > 0) begin
                chk("run_sig_step", {16'b0, sig}, {16'b0, sb.pop_front()});
            end else begin
                chk("run_sb_empty", 32'd0, 32'd1);
            end
        end
        chk("run_done", {31'b0, done}, 32'd1);
        chk("run_busy_end", {31'b0, busy}, 32'd0);
        chk("run_stim_valid_end", {31'b0, stim_valid}, 32'd0);
        chk("run_final_sig", {16'b0, sig}, {16'b0, v.exp_sig});
        chk("run_pass", {31'b0, pass}, {31'b0, v.exp_pass});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{gold: 16'h0073, zero: 1'b0, mid_start: -1, exp_sig: 16'h0073, exp_pass: 1'b1};
        vecs[1] = '{gold: 16'h0074, zero: 1'b0, mid_start: -1, exp_sig: 16'h0073, exp_pass: 1'b0};
        vecs[2] = '{gold: 16'h0000, zero: 1'b1, mid_start: -1, exp_sig: 16'h0000, exp_pass: 1'b1};
        vecs[3] = '{gold: 16'h0073, zero: 1'b0, mid_start: 3,  exp_sig: 16'h0073, exp_pass: 1'b1};
        vecs[4] = '{gold: 16'h1234, zero: 1'b1, mid_start: -1, exp_sig: 16'h0000, exp_pass: 1'b0};

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        golden    = 16'h0000;
        zero_resp = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stim", {29'b0, stim}, 32'd0);
        chk("rst_stim_valid", {31'b0, stim_valid}, 32'd0);
        chk("rst_sig", {16'b0, sig}, 32'h0000);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_pass", {31'b0, pass}, 32'd0);
        chk("rst_sig_seeded", {16'b0, sig_sd}, 32'h8000);
        rst_n = 1'b1;
        @(negedge clk);

        // Registered-DUT instance and seeded instance share this run.
        golden = 16'h0073;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("l1_stim0", {29'b0, stim_l1}, 32'd0);
        chk("sd_seed_loaded", {16'b0, sig_sd}, 32'h8000);
        @(negedge clk);
        chk("sd_feedback", {16'b0, sig_sd}, 32'h1021);
        repeat (7) @(negedge clk);
        chk("main_done_before_l1", {31'b0, done}, 32'd1);
        chk("l1_drain_busy", {31'b0, busy_l1}, 32'd1);
        chk("l1_drain_stim_valid", {31'b0, stim_valid_l1}, 32'd0);
        chk("l1_drain_not_done", {31'b0, done_l1}, 32'd0);
        @(negedge clk);
        chk("l1_done", {31'b0, done_l1}, 32'd1);
        chk("l1_sig", {16'b0, sig_l1}, 32'h0073);
        chk("l1_pass", {31'b0, pass_l1}, 32'd1);

        foreach (vecs[i]) run_main(vecs[i]);

        // start together with abort: abort wins and the controller stays idle.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", {31'b0, busy}, 32'd0);
        chk("sa_done", {31'b0, done}, 32'd0);
        chk("sa_pass", {31'b0, pass}, 32'd0);
        chk("sa_sig_hold", {16'b0, sig}, 32'h0000);

        // Abort while stim=4.
        golden    = 16'h0073;
        zero_resp = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("ab_stim4", {29'b0, stim}, 32'd4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", {31'b0, busy}, 32'd0);
        chk("ab_stim_valid", {31'b0, stim_valid}, 32'd0);
        chk("ab_done", {31'b0, done}, 32'd0);
        chk("ab_pass", {31'b0, pass}, 32'd0);
        chk("ab_sig", {16'b0, sig}, 32'h000E);
        @(negedge clk);
        chk("ab_sig_frozen", {16'b0, sig}, 32'h000E);
        run_main(vecs[0]);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", {31'b0, busy}, 32'd0);
        chk("mr_stim", {29'b0, stim}, 32'd0);
        chk("mr_stim_valid", {31'b0, stim_valid}, 32'd0);
        chk("mr_sig", {16'b0, sig}, 32'h0000);
        chk("mr_done", {31'b0, done}, 32'd0);
        chk("mr_pass", {31'b0, pass}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("mr_no_done", {31'b0, done}, 32'd0);
        chk("mr_idle", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
